div_issue_ctrl: RTL
===================

# div_issue_ctrl

Sequential issue/capture stage for the combinational floating-point `Divider`. It accepts a divide request over a valid/ready handshake and registers the operands into `Divider.src1`/`src2`. It then holds them stable for a fixed settle window, so the divider path is timed as a multi-cycle path. At the end of the window it captures `divOut`/`divFlag` into an output register, presented downstream over a second valid/ready handshake. It sits between the ALU operand bus and the `Divider` instance on the input side, and between the `Divider` and the ALU result mux on the output side.

## Interface
- `WIDTH`, 32, operand/result width (IEEE-754 single).
- `SETTLE_CYCLES`, 4, cycles the operands are held before the result is sampled; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `inValid`  in  1  request valid.
- `inReady`  out  1  stage can accept a request this cycle.
- `inSrc1`  in  WIDTH  dividend.
- `inSrc2`  in  WIDTH  divisor.
- `divSrc1`  out  WIDTH  registered dividend, drives `Divider.src1`.
- `divSrc2`  out  WIDTH  registered divisor, drives `Divider.src2`.
- `divOut`  in  WIDTH  quotient from `Divider`.
- `divFlag`  in  1  flag from `Divider`.
- `outValid`  out  1  result valid.
- `outReady`  in  1  consumer accepts result.
- `outData`  out  WIDTH  captured quotient.
- `outFlag`  out  1  captured flag.
- `busy`  out  1  high in SETTLE.

## Operation
- FSM states: IDLE, SETTLE, DONE. A 4-bit down-counter `cnt` times the settle window.
- **IDLE:**
  - `inReady`=1.
  - On `inValid`: load `divSrc1`/`divSrc2` from `inSrc1`/`inSrc2`, load `cnt`=SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE:**
  - `inReady`=0, `busy`=1.
  - `divSrc*` held constant.
  - If `cnt`≠0: decrement.
  - If `cnt`=0: capture `outData`←`divOut`, `outFlag`←`divFlag`, set `outValid`=1, go to DONE.
- **DONE:**
  - `outValid`=1. `outData`/`outFlag` are held stable while `outReady`=0.
  - `inReady`=`outReady` (combinational), giving zero-bubble back-to-back issue.
  - If `outReady` and `inValid`: result is consumed, new operands are loaded, `cnt` is reloaded, and the FSM goes to SETTLE. `outValid` drops the next cycle.
  - If `outReady` and not `inValid`: `outValid`←0, go to IDLE.
- `divSrc1`/`divSrc2` are never cleared after an operation. They keep the last operands so the divider inputs do not toggle while idle.
- The block does not interpret operands or flags. Special cases (zero divisor, NaN) are entirely the `Divider`'s responsibility; `outFlag` is a verbatim sample of `divFlag`.
- `inValid` in SETTLE is ignored and its payload is not latched. The upstream source must hold the request until `inReady`.
- `inValid`/`inSrc*` may change freely while `inReady`=0.

## Timing
- Reset values (at the edge where `reset`=1): state IDLE, `cnt`=0, `divSrc1`=`divSrc2`=0, `outData`=0, `outFlag`=0, `outValid`=0, `busy`=0. `inReady` is 1 in the following cycle.
- `reset` wins over every other event, including an accept or capture in the same cycle. Reset mid-SETTLE discards the operation with no output.
- Latency: accept at edge E0. `divOut` is sampled at edge E0+SETTLE_CYCLES, and `outValid` is high in the cycle after that edge.
  - SETTLE_CYCLES=1 gives a sample at the first edge after accept.
- Throughput, with the consumer always ready: one result per SETTLE_CYCLES+1 cycles (SETTLE_CYCLES cycles in SETTLE plus one DONE cycle with simultaneous accept).
- `divOut` is sampled only at the capture edge. Values on `divOut` earlier in SETTLE do not affect `outData`.
- `outData`/`outFlag`/`outValid` change only at a clock edge. No combinational path runs from `divOut` to `outData`.

## Test plan
- Reset, then a single op with `inSrc1`=0x41000000 (8.0), `inSrc2`=0x40000000 (2.0), real `Divider`, SETTLE_CYCLES=4 -> `outValid` rises exactly 4 edges after accept, `outData`=0x40800000 (4.0), `busy` is high for 4 cycles.
- Back-to-back requests 6.0/2.0 (0x40C00000/0x40000000) then 4.0/2.0 (0x40800000/0x40000000) with `outReady`=1 and `inValid` held -> results 0x40400000 then 0x40000000. The second accept lands in the DONE cycle of the first, so the second `outValid` is 5 cycles after the first.
- Backpressure: `outReady`=0 for 10 cycles after 2.0/2.0 completes -> `outData`=0x3F800000 stays stable, `inReady`=0 throughout, and a pending `inValid` is accepted on the cycle `outReady` rises.
- Capture timing with a stub divider: `divOut` is 0xDEADBEEF until the cycle before the capture edge, then 0x12345678 with `divFlag`=1 -> `outData`=0x12345678, `outFlag`=1.
- Reset asserted mid-SETTLE (cycle 2 of 4) -> the next cycle has all outputs at reset values and `inReady`=1; no stale `outValid` appears afterwards.
- SETTLE_CYCLES=1 with op 8.0/2.0 -> `outValid` one edge after accept, `outData`=0x40800000.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue/capture stage around a combinational FP divider: registers operands,
// holds them for a fixed settle window, then captures the quotient for a downstream handshake.
module div_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inSrc1,
  input  logic [WIDTH-1:0] inSrc2,
  output logic [WIDTH-1:0] divSrc1,
  output logic [WIDTH-1:0] divSrc2,
  input  logic [WIDTH-1:0] divOut,
  input  logic             divFlag,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic             outFlag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_flag_q, out_flag_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    out_data_d  = out_data_q;
    out_flag_d  = out_flag_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (inValid) begin
          src1_d  = inSrc1;
          src2_d  = inSrc2;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // The divider output is only trusted at the final edge of the window.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d  = divOut;
          out_flag_d  = divFlag;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Accepting while the result drains avoids a bubble between operations.
        in_ready = outReady;
        if (outReady) begin
          out_valid_d = 1'b0;
          if (inValid) begin
            src1_d  = inSrc1;
            src2_d  = inSrc2;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      src1_q      <= '0;
      src2_q      <= '0;
      out_data_q  <= '0;
      out_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      out_data_q  <= out_data_d;
      out_flag_q  <= out_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign inReady  = in_ready;
  assign divSrc1  = src1_q;
  assign divSrc2  = src2_q;
  assign outData  = out_data_q;
  assign outFlag  = out_flag_q;
  assign outValid = out_valid_q;
  assign busy     = (state_q == SETTLE);

endmodule
